bit_unstuffer: RTL and testbench
================================

// Module: bit_unstuffer
// PURPOSE
// - USB receive-path stage directly upstream of the bit-stream decoder. Input is the NRZI-decoded serial stream.
// - Removes the stuffed 0 that follows every MAX_ONES consecutive 1s and flags a stuffing violation.
// - Delivers a framed bit stream (start_decode / end_decode / s_out / out_valid) to the decoder.
// - A one-bit hold register delays output so end_decode always coincides with a real data bit.
// PARAMETERS
// - MAX_ONES  6   run of consecutive 1s after which the next input bit is a stuffed bit
// - CNT_W     11  width of bit_count (emitted data bits per packet); saturating
// PORTS
// - clk            in   1      single clock; all state on posedge
// - rst            in   1      asynchronous, active-high reset
// - abort          in   1      synchronous packet abort; returns to IDLE next edge
// - in_valid       in   1      qualifies s_in/start_unstuff/end_unstuff (one bit slot)
// - s_in           in   1      NRZI-decoded bit
// - start_unstuff  in   1      with in_valid: first bit of packet
// - end_unstuff    in   1      with in_valid: last bit of packet (may be a stuffed bit)
// - err_ack        in   1      protocol FSM acknowledges stuff_error
// - s_out          out  1      unstuffed data bit, valid when out_valid
// - out_valid      out  1      one-cycle strobe per emitted data bit
// - start_decode   out  1      with out_valid: first data bit of packet
// - end_decode     out  1      with out_valid: last data bit of packet
// - stuff_error    out  1      stuffing violation; level, held until err_ack
// - unstuffer_wait out  1      high in IDLE (ready for new packet)
// - bit_count      out  CNT_W  data bits emitted in current packet
// BEHAVIOUR
// - Reset: state=IDLE; s_out, out_valid, start_decode, end_decode, stuff_error, bit_count = 0; unstuffer_wait = 1.
// - Reset also clears ones_cnt, hold_vld and first flag.
// - All outputs registered. Emitted bit appears the cycle after the in_valid that releases it.
// - States: IDLE, RUN, FLUSH, ERROR. abort has priority over every transition except rst.
// - IDLE: in_valid&start_unstuff -> capture s_in in hold, set first flag, clear bit_count.
//   - ones_cnt = s_in ? 1 : 0. Go RUN.
//   - If end_unstuff is also set: go FLUSH (single-bit packet).
// - RUN, in_valid, ones_cnt<MAX_ONES (data bit):
//   - If hold_vld: emit hold with out_valid=1; start_decode=first; then clear first.
//   - Load s_in into hold. ones_cnt = s_in ? ones_cnt+1 : 0.
//   - If end_unstuff: go FLUSH.
// - RUN, in_valid, ones_cnt==MAX_ONES (stuffed slot):
//   - s_in=0: drop bit; ones_cnt=0; nothing emitted.
//     - If end_unstuff: emit hold with end_decode=1 (start_decode=first); go IDLE.
//   - s_in=1: violation (see CONFIGURATION).
// - FLUSH: emit hold with out_valid=1, end_decode=1, start_decode=first; go IDLE. Lasts one cycle; input ignored.
// - ERROR: stuff_error=1; all input ignored; out_valid=0.
//   - err_ack -> IDLE; stuff_error falls the following cycle.
// - bit_count increments on each emitted bit; saturates at 2**CNT_W-1; held after end until next start.
// - in_valid with start_unstuff while in RUN: treated as abort + new start. Old packet dropped with no end_decode.
// - ones_cnt counts across the hold boundary (counts input data bits, not output).
// - Inputs are ignored when in_valid=0. end_unstuff without in_valid has no effect.
// CONFIGURATION
// - Macro UNSTUFF_ERR_CHECK_EN.
// - Defined: stuffed-slot 1 -> stuff_error=1 next cycle, hold discarded (no end_decode), state ERROR.
// - Undefined: stuffed-slot 1 dropped like a stuffed 0 (ones_cnt=0, end handling identical).
//   - stuff_error tied 0; ERROR state and err_ack unused.
// TESTING
// - Start; bits 1,0,1,1, end on last -> s_out 1,0,1,1.
//   - start_decode on first strobe, end_decode on fourth; bit_count=4; unstuffer_wait=1 after.
// - Bits 1x6,0,1, end on last -> 7 strobes all 1; stuffed 0 absent; bit_count=7.
// - Bits 1x6,0 with end on the 0 -> 6 strobes; end_decode on sixth 1; no FLUSH cycle.
// - [EN] bits 1x7 -> stuff_error=1, no end_decode, stuck in ERROR.
//   - err_ack pulse -> stuff_error=0, unstuffer_wait=1.
// - Single bit 0 with start_unstuff&end_unstuff -> one strobe with start_decode=end_decode=1; bit_count=1.
// - abort after 3 bits of a packet -> next cycle IDLE; out_valid=0, no end_decode.
//   - Next packet counts from bit_count=1.

Source files
------------

// File: rtl/bit_unstuffer.sv
// bit_unstuffer: USB receive-path bit unstuffer.
// Drops the stuffed 0 that follows every MAX_ONES consecutive 1s in the
// NRZI-decoded stream. It frames the surviving data bits for the bit-stream
// decoder using start_decode, end_decode, s_out and out_valid.
// A one-bit hold register delays output by one data bit. This lets
// end_decode always land on a real data bit, even when the packet's last
// input bit is a stuffed bit.
// Optional feature: define UNSTUFF_ERR_CHECK_EN to flag a 1 in a stuffed
// slot as a stuffing violation. The design then parks in ERROR until
// err_ack arrives. With the macro undefined, that bit is silently dropped.
module bit_unstuffer #(
  parameter int MAX_ONES = 6,
  parameter int CNT_W    = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic             in_valid,
  input  logic             s_in,
  input  logic             start_unstuff,
  input  logic             end_unstuff,
  input  logic             err_ack,
  output logic             s_out,
  output logic             out_valid,
  output logic             start_decode,
  output logic             end_decode,
  output logic             stuff_error,
  output logic             unstuffer_wait,
  output logic [CNT_W-1:0] bit_count
);

  localparam int OW = $clog2(MAX_ONES + 1);
  localparam logic [OW-1:0]    ONES_MAX = OW'(MAX_ONES);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, ERROR} state_t;

  state_t           state_q, state_d;
  logic             hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic             first_q, first_d;
  logic [OW-1:0]    ones_cnt_q, ones_cnt_d;
  logic             s_out_q, s_out_d;
  logic             out_valid_q, out_valid_d;
  logic             start_decode_q, start_decode_d;
  logic             end_decode_q, end_decode_d;
  logic             stuff_error_q, stuff_error_d;
  logic             unstuffer_wait_q, unstuffer_wait_d;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;
  logic             emit, emit_end;

`ifndef UNSTUFF_ERR_CHECK_EN
  // Without violation checking the acknowledge has nothing to acknowledge.
  logic unused_err_ack;
  assign unused_err_ack = err_ack;
`endif

  // Next-state, hold/counter updates and the registered output strobe.
  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    hold_vld_d     = hold_vld_q;
    first_d        = first_q;
    ones_cnt_d     = ones_cnt_q;
    s_out_d        = s_out_q;
    out_valid_d    = 1'b0;
    start_decode_d = 1'b0;
    end_decode_d   = 1'b0;
    stuff_error_d  = stuff_error_q;
    bit_count_d    = bit_count_q;
    emit           = 1'b0;
    emit_end       = 1'b0;

    if (abort) begin
      state_d       = IDLE;
      hold_vld_d    = 1'b0;
      first_d       = 1'b0;
      ones_cnt_d    = '0;
      stuff_error_d = 1'b0;
    end else if (in_valid && start_unstuff && (state_q == IDLE || state_q == RUN)) begin
      // A start while RUN restarts: the old packet is dropped without end_decode.
      hold_d      = s_in;
      hold_vld_d  = 1'b1;
      first_d     = 1'b1;
      bit_count_d = '0;
      ones_cnt_d  = s_in ? OW'(1) : '0;
      state_d     = end_unstuff ? FLUSH : RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (in_valid) begin
            if (ones_cnt_q != ONES_MAX) begin
              // Data bit: release the held bit and hold the new one.
              emit       = hold_vld_q;
              hold_d     = s_in;
              hold_vld_d = 1'b1;
              ones_cnt_d = s_in ? ones_cnt_q + OW'(1) : '0;
              if (end_unstuff) state_d = FLUSH;
            end else begin
`ifdef UNSTUFF_ERR_CHECK_EN
              if (s_in) begin
                state_d       = ERROR;
                stuff_error_d = 1'b1;
                hold_vld_d    = 1'b0;
                ones_cnt_d    = '0;
              end else
`endif
              begin
                // Stuffed slot: drop the bit. A packet ending here closes on the held bit.
                ones_cnt_d = '0;
                if (end_unstuff) begin
                  emit       = hold_vld_q;
                  emit_end   = 1'b1;
                  hold_vld_d = 1'b0;
                  state_d    = IDLE;
                end
              end
            end
          end
        end
        FLUSH: begin
          emit       = hold_vld_q;
          emit_end   = 1'b1;
          hold_vld_d = 1'b0;
          state_d    = IDLE;
        end
        ERROR: begin
`ifdef UNSTUFF_ERR_CHECK_EN
          if (err_ack) begin
            state_d       = IDLE;
            stuff_error_d = 1'b0;
          end
`else
          state_d = IDLE;
`endif
        end
        default: ;
      endcase
    end

    if (emit) begin
      out_valid_d    = 1'b1;
      s_out_d        = hold_q;
      start_decode_d = first_q;
      end_decode_d   = emit_end;
      first_d        = 1'b0;
      if (bit_count_q != CNT_SAT) bit_count_d = bit_count_q + CNT_W'(1);
    end

    unstuffer_wait_d = (state_d == IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      hold_q           <= 1'b0;
      hold_vld_q       <= 1'b0;
      first_q          <= 1'b0;
      ones_cnt_q       <= '0;
      s_out_q          <= 1'b0;
      out_valid_q      <= 1'b0;
      start_decode_q   <= 1'b0;
      end_decode_q     <= 1'b0;
      stuff_error_q    <= 1'b0;
      unstuffer_wait_q <= 1'b1;
      bit_count_q      <= '0;
    end else begin
      state_q          <= state_d;
      hold_q           <= hold_d;
      hold_vld_q       <= hold_vld_d;
      first_q          <= first_d;
      ones_cnt_q       <= ones_cnt_d;
      s_out_q          <= s_out_d;
      out_valid_q      <= out_valid_d;
      start_decode_q   <= start_decode_d;
      end_decode_q     <= end_decode_d;
      stuff_error_q    <= stuff_error_d;
      unstuffer_wait_q <= unstuffer_wait_d;
      bit_count_q      <= bit_count_d;
    end
  end

  assign s_out          = s_out_q;
  assign out_valid      = out_valid_q;
  assign start_decode   = start_decode_q;
  assign end_decode     = end_decode_q;
  assign stuff_error    = stuff_error_q;
  assign unstuffer_wait = unstuffer_wait_q;
  assign bit_count      = bit_count_q;

endmodule

// File: tb/tb_bit_unstuffer.sv
// Directed testbench for bit_unstuffer with hand-computed expectations.
// Emitted strobes are logged as shift registers: the oldest strobe sits in
// the highest bit of each log.
module tb_bit_unstuffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        abort, in_valid, s_in, start_unstuff, end_unstuff, err_ack;
  logic        s_out, out_valid, start_decode, end_decode, stuff_error, unstuffer_wait;
  logic [10:0] bit_count;

  int          n_err = 0;
  int          n_chk = 0;
  int          n_str;
  logic [15:0] data_log, st_log, en_log;

  bit_unstuffer #(.MAX_ONES(6), .CNT_W(11)) dut (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .s_in(s_in),
    .start_unstuff(start_unstuff), .end_unstuff(end_unstuff), .err_ack(err_ack),
    .s_out(s_out), .out_valid(out_valid), .start_decode(start_decode),
    .end_decode(end_decode), .stuff_error(stuff_error),
    .unstuffer_wait(unstuffer_wait), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_str = 0; data_log = '0; st_log = '0; en_log = '0;
  endtask

  // One clock cycle of stimulus. Outputs are sampled 1 time unit after the edge.
  task automatic step(input logic v, input logic b, input logic st, input logic en,
                      input logic ab, input logic ack);
    in_valid = v; s_in = b; start_unstuff = st; end_unstuff = en; abort = ab; err_ack = ack;
    @(posedge clk); #1;
    in_valid = 0; s_in = 0; start_unstuff = 0; end_unstuff = 0; abort = 0; err_ack = 0;
    if (out_valid === 1'b1) begin
      n_str++;
      data_log = {data_log[14:0], s_out};
      st_log   = {st_log[14:0], start_decode};
      en_log   = {en_log[14:0], end_decode};
      $display("strobe %0d: s_out=%0b start=%0b end=%0b bit_count=%0d",
               n_str, s_out, start_decode, end_decode, bit_count);
    end
  endtask

  task automatic send(input logic b, input logic st, input logic en);
    step(1'b1, b, st, en, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; abort = 0; in_valid = 0; s_in = 0; start_unstuff = 0; end_unstuff = 0; err_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_s_out", 32'(s_out), 32'd0);
    chk("rst_start", 32'(start_decode), 32'd0);
    chk("rst_end", 32'(end_decode), 32'd0);
    chk("rst_err", 32'(stuff_error), 32'd0);
    chk("rst_cnt", 32'(bit_count), 32'd0);
    chk("rst_wait", 32'(unstuffer_wait), 32'd1);
    rst = 1'b0;

    // Packet 1: 1,0,1,1 with an in_valid=0 gap carrying a stray end_unstuff.
    clr();
    send(1, 1, 0);
    chk("p1_wait_busy", 32'(unstuffer_wait), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send(0, 0, 0);
    send(1, 0, 0);
    send(1, 0, 1);
    chk("p1_flush_wait", 32'(unstuffer_wait), 32'd0);
    idle();
    chk("p1_n", 32'(n_str), 32'd4);
    chk("p1_data", 32'(data_log[3:0]), 32'b1011);
    chk("p1_start", 32'(st_log[3:0]), 32'b1000);
    chk("p1_end", 32'(en_log[3:0]), 32'b0001);
    chk("p1_cnt", 32'(bit_count), 32'd4);
    chk("p1_wait", 32'(unstuffer_wait), 32'd1);

    // Packet 2: 1x6, stuffed 0, 1 (end) -> seven 1s.
    clr();
    send(1, 1, 0);
    repeat (5) send(1, 0, 0);
    send(0, 0, 0);
    send(1, 0, 1);
    idle();
    chk("p2_n", 32'(n_str), 32'd7);
    chk("p2_data", 32'(data_log[6:0]), 32'h7f);
    chk("p2_start", 32'(st_log[6:0]), 32'b1000000);
    chk("p2_end", 32'(en_log[6:0]), 32'b0000001);
    chk("p2_cnt", 32'(bit_count), 32'd7);

    // Packet 3: 1x6 then stuffed 0 carrying end -> six strobes, no FLUSH cycle.
    clr();
    send(1, 1, 0);
    repeat (5) send(1, 0, 0);
    send(0, 0, 1);
    chk("p3_end_now", 32'(end_decode), 32'd1);
    chk("p3_wait_now", 32'(unstuffer_wait), 32'd1);
    idle();
    chk("p3_n", 32'(n_str), 32'd6);
    chk("p3_data", 32'(data_log[5:0]), 32'h3f);
    chk("p3_end", 32'(en_log[5:0]), 32'b000001);
    chk("p3_cnt", 32'(bit_count), 32'd6);

`ifdef UNSTUFF_ERR_CHECK_EN
    // Packet 4: 1x7 -> violation, stays in ERROR until err_ack.
    clr();
    send(1, 1, 0);
    repeat (6) send(1, 0, 0);
    chk("p4_err", 32'(stuff_error), 32'd1);
    chk("p4_wait", 32'(unstuffer_wait), 32'd0);
    repeat (2) idle();
    send(0, 0, 1);
    chk("p4_err_held", 32'(stuff_error), 32'd1);
    chk("p4_wait_held", 32'(unstuffer_wait), 32'd0);
    chk("p4_n", 32'(n_str), 32'd5);
    chk("p4_no_end", 32'(en_log), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("p4_ack_err", 32'(stuff_error), 32'd0);
    chk("p4_ack_wait", 32'(unstuffer_wait), 32'd1);
`else
    // Packet 4: 1x7 then 0 (end) -> seventh 1 dropped like a stuffed 0.
    clr();
    send(1, 1, 0);
    repeat (6) send(1, 0, 0);
    send(0, 0, 1);
    idle();
    chk("p4_err", 32'(stuff_error), 32'd0);
    chk("p4_n", 32'(n_str), 32'd7);
    chk("p4_data", 32'(data_log[6:0]), 32'b1111110);
    chk("p4_end", 32'(en_log[6:0]), 32'b0000001);
    chk("p4_cnt", 32'(bit_count), 32'd7);
`endif

    // Packet 5: single bit 0 with start and end together.
    clr();
    send(0, 1, 1);
    chk("p5_flush_wait", 32'(unstuffer_wait), 32'd0);
    idle();
    chk("p5_n", 32'(n_str), 32'd1);
    chk("p5_data", 32'(data_log[0]), 32'd0);
    chk("p5_start", 32'(st_log[0]), 32'd1);
    chk("p5_end", 32'(en_log[0]), 32'd1);
    chk("p5_cnt", 32'(bit_count), 32'd1);

    // Packet 6: abort after three bits, then a fresh two-bit packet.
    clr();
    send(1, 1, 0);
    send(0, 0, 0);
    send(1, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("p6_abort_wait", 32'(unstuffer_wait), 32'd1);
    chk("p6_abort_valid", 32'(out_valid), 32'd0);
    repeat (2) idle();
    chk("p6_n", 32'(n_str), 32'd2);
    chk("p6_no_end", 32'(en_log), 32'd0);
    chk("p6_cnt_held", 32'(bit_count), 32'd2);
    clr();
    send(0, 1, 0);
    send(1, 0, 1);
    chk("p7_first_valid", 32'(out_valid), 32'd1);
    chk("p7_first_start", 32'(start_decode), 32'd1);
    chk("p7_first_cnt", 32'(bit_count), 32'd1);
    idle();
    chk("p7_n", 32'(n_str), 32'd2);
    chk("p7_data", 32'(data_log[1:0]), 32'b01);
    chk("p7_end", 32'(en_log[1:0]), 32'b01);
    chk("p7_cnt", 32'(bit_count), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
